// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode constants, mux-select enums and control state encoding
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTYPE_EX, ALU_WB, ADDI_EX, BEQ, JUMP, ERROR
    } ctrl_state_t;

endpackage

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle MIPS main control FSM driving datapath enables and selects
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           pc_write,
    output logic           branch,
    output logic           i_or_d,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_src,
    output logic           err
);

    ctrl_state_t state_q, state_d;
    logic        reg_dst_q;
    logic [5:0]  op6;
    alu_src_b_t  src_b_c;
    alu_op_t     alu_op_c;
    pc_src_t     pc_src_c;

    assign op6 = 6'(opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            reg_dst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == RTYPE_EX)
                reg_dst_q <= 1'b1;
            else if (state_q == ADDI_EX)
                reg_dst_q <= 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        branch     = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        src_b_c    = SRCB_REG;
        alu_op_c   = ALU_ADD;
        pc_src_c   = PCSRC_ALU;
        err        = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                src_b_c  = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                src_b_c = SRCB_IMM_SH;
                case (op6)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPE_EX;
                    OP_ADDI:      state_d = ADDI_EX;
                    OP_BEQ:       state_d = BEQ;
                    OP_J:         state_d = JUMP;
                    default:      state_d = ERROR;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                src_b_c   = SRCB_IMM;
                state_d   = (op6 == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)
                    state_d = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)
                    state_d = FETCH;
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                src_b_c   = SRCB_REG;
                alu_op_c  = ALU_FUNCT;
                state_d   = ALU_WB;
            end
            ADDI_EX: begin
                alu_src_a = 1'b1;
                src_b_c   = SRCB_IMM;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = reg_dst_q;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a = 1'b1;
                src_b_c   = SRCB_REG;
                alu_op_c  = ALU_SUB;
                branch    = 1'b1;
                pc_src_c  = PCSRC_ALUOUT;
                state_d   = FETCH;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src_c = PCSRC_JUMP;
                state_d  = FETCH;
            end
            ERROR: begin
                err = 1'b1;
            end
            default: state_d = ERROR;
        endcase

        // Reset blanks every strobe in the same cycle so no partial write escapes.
        if (rst) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            src_b_c    = SRCB_REG;
            alu_op_c   = ALU_ADD;
            pc_src_c   = PCSRC_ALU;
            err        = 1'b0;
        end
    end

    assign alu_src_b = src_b_c;
    assign alu_op    = alu_op_c;
    assign pc_src    = pc_src_c;
    assign pc_en     = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - scoreboard bench for the multicycle control FSM
module tb_mips_mc_control;

    typedef struct packed {
        logic       pc_en, pc_write, branch, i_or_d, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       err;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, pc_write, branch, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    ctl_t       got;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mips_mc_control #(.OPW(6)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_write(pc_write), .branch(branch), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .err(err)
    );

    assign got = {pc_en, pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, err};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s t=%0t got=%05h exp=%05h", t, $time, got, e);
            end
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] ropcode();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
    endfunction

    task automatic step(input logic r, input logic mr, input logic z, input logic [5:0] op,
                        input ctl_t e, input string tag);
        @(posedge clk);
        #1;
        rst = r; mem_ready = mr; zero = z; opcode = op;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, rbit(), rbit(), ropcode(), '0, "reset");
    endtask

    task automatic fetch_decode(input logic [5:0] op, input int fw);
        ctl_t e;
        e = '0; e.mem_read = 1; e.alu_src_b = 2'b01;
        for (int i = 0; i < fw; i++) step(1'b0, 1'b0, rbit(), ropcode(), e, "fetch_wait");
        e.ir_write = 1; e.pc_write = 1; e.pc_en = 1;
        step(1'b0, 1'b1, rbit(), ropcode(), e, "fetch");
        e = '0; e.alu_src_b = 2'b11;
        step(1'b0, rbit(), rbit(), op, e, "decode");
    endtask

    // Expected cycle sequence of one instruction, written from the instruction's cycle recipe.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic bz,
                             input int err_cycles);
        ctl_t e;
        fetch_decode(op, fw);
        case (op)
            6'h23, 6'h2B: begin
                e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
                step(1'b0, rbit(), rbit(), op, e, "memadr");
                e = '0; e.i_or_d = 1;
                if (op == 6'h23) e.mem_read = 1; else e.mem_write = 1;
                for (int i = 0; i < mw; i++) step(1'b0, 1'b0, rbit(), op, e, "mem_wait");
                step(1'b0, 1'b1, rbit(), op, e, "mem_done");
                if (op == 6'h23) begin
                    e = '0; e.reg_write = 1; e.mem_to_reg = 1;
                    step(1'b0, rbit(), rbit(), op, e, "memwb");
                end
            end
            6'h00, 6'h08: begin
                e = '0; e.alu_src_a = 1;
                if (op == 6'h00) e.alu_op = 2'b10; else e.alu_src_b = 2'b10;
                step(1'b0, rbit(), rbit(), op, e, "alu_ex");
                e = '0; e.reg_write = 1; e.reg_dst = (op == 6'h00);
                step(1'b0, rbit(), rbit(), op, e, "alu_wb");
            end
            6'h04: begin
                e = '0; e.alu_src_a = 1; e.alu_op = 2'b01; e.branch = 1; e.pc_src = 2'b01;
                e.pc_en = bz;
                step(1'b0, rbit(), bz, op, e, "beq");
            end
            6'h02: begin
                e = '0; e.pc_write = 1; e.pc_src = 2'b10; e.pc_en = 1;
                step(1'b0, rbit(), rbit(), op, e, "jump");
            end
            default: begin
                e = '0; e.err = 1;
                for (int i = 0; i < err_cycles; i++)
                    step(1'b0, rbit(), rbit(), ropcode(), e, "error_hold");
                do_reset(1);
            end
        endcase
    endtask

    initial begin
        ctl_t e;
        logic [5:0] op;
        int sel;
        do_reset(2);

        run_instr(6'h08, 0, 0, 1'b0, 0);
        run_instr(6'h23, 0, 2, 1'b0, 0);
        run_instr(6'h04, 0, 0, 1'b1, 0);
        run_instr(6'h04, 0, 0, 1'b0, 0);
        run_instr(6'h02, 0, 0, 1'b0, 0);
        run_instr(6'h2B, 0, 0, 1'b0, 0);
        run_instr(6'h00, 1, 0, 1'b0, 0);
        run_instr(6'h3F, 0, 0, 1'b0, 22);

        // Reset landing while a store is still waiting on memory.
        fetch_decode(6'h2B, 0);
        e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
        step(1'b0, 1'b1, 1'b0, 6'h2B, e, "memadr");
        e = '0; e.mem_write = 1; e.i_or_d = 1;
        step(1'b0, 1'b0, 1'b0, 6'h2B, e, "memwr_wait");
        step(1'b1, 1'b0, 1'b0, 6'h2B, '0, "rst_mid");
        step(1'b1, 1'b1, 1'b0, 6'h2B, '0, "rst_mid2");
        run_instr(6'h08, 0, 0, 1'b0, 0);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: op = 6'h00;
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                5: op = 6'h02;
                default: begin
                    op = ropcode();
                    while (legal(op)) op = ropcode();
                end
            endcase
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rbit(),
                      $urandom_range(20, 24));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
